mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Responder end of the single-port memory read/write bus: a synchronous DEPTH x DATA_W storage array that services `read` and `write` strobes issued by a bus initiator (for example the memory test bench driver).
- Registered read data is valid one clock after a read strobe.
- A hardware clear sequencer zeroes the array after reset, so the initiator sees known contents.
- Flags protocol violations (simultaneous read and write, access while busy).

Parameters:
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 8, data word width.
- CLEAR_ON_RESET, 1, 1 = run the clear sequence after reset; 0 = skip it (array contents undefined, `ready` high immediately).
- CNT_W, 16, width of the access counters (STATS_EN only).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- read  input  1  read strobe, sampled at the rising edge.
- write  input  1  write strobe, sampled at the rising edge.
- addr  input  ADDR_W  word address.
- data_in  input  DATA_W  write data.
- data_out  output  DATA_W  registered read data.
- ready  output  1  high when the block accepts accesses.
- err_collision  output  1  sticky: read and write sampled high together.
- err_busy  output  1  sticky: strobe sampled while ready=0.
- rd_count  output  CNT_W  reads completed (STATS_EN only).
- wr_count  output  CNT_W  writes completed (STATS_EN only).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - data_out=0, ready=0, err_collision=0, err_busy=0, counters=0.
  - FSM goes to CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - Array contents are not reset directly.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Internal clr_ptr starts at 0; each cycle writes 0 to array[clr_ptr] and increments clr_ptr.
  - When clr_ptr = DEPTH-1 is written, go to IDLE next cycle.
  - CLEAR lasts exactly DEPTH cycles; ready goes high on the edge that enters IDLE.
  - Bus strobes in CLEAR are ignored and set err_busy.
- Reset asserted mid-CLEAR: clr_ptr returns to 0 and the clear sequence restarts from address 0 after release.
- IDLE, write=1, read=0: array[addr] <= data_in on that edge; data_out unchanged.
- IDLE, read=1, write=0: data_out <= array[addr] on that edge, so data is valid after the edge (latency 1).
  - data_out holds its value until the next accepted read.
- Read-after-write to the same address in consecutive cycles returns the new data; there are no bypass hazards because the write commits on the earlier edge.
- IDLE, read=1 and write=1 together:
  - Neither operation performed; data_out and array unchanged.
  - err_collision set.
- Error flags are sticky until reset.
- Address wrap: addr is exactly ADDR_W bits, so no out-of-range addresses exist.
- Strobe level: a strobe held high for N cycles is N accesses; no edge detection.

Optional Feature:
- Macro: MEM_RESPONDER_STATS_EN.
- Defined:
  - rd_count increments on each accepted read; wr_count increments on each accepted write.
  - Both saturate at 2**CNT_W-1 and never wrap.
  - Collisions, busy strobes and clear-sequence writes are not counted.
- Undefined: rd_count and wr_count ports and their logic are absent.

Test Plan:
- Reset release with CLEAR_ON_RESET=1, no strobes → ready=0 for exactly 32 cycles, then ready=1; reading addresses 0..31 gives 8'h00 at each.
- Write addr=5'h0A data=8'hA5, then read addr=5'h0A next cycle → data_out=8'hA5 one edge after the read strobe; data_out stays 8'hA5 through following idle cycles.
- Write each addr 0..31 with data=addr, then read all → data_out=addr for every address, err flags remain 0.
- read=1 and write=1 at addr=3 with data_in=8'hFF → err_collision=1, subsequent read of addr 3 returns prior value (8'h00 after clear), data_out not updated on the collision edge.
- Strobe write at cycle 10 of CLEAR, then assert rst_n=0 at cycle 20 and release → err_busy=1 before reset, 0 after; clear restarts with a full 32-cycle ready=0 window.
- MEM_RESPONDER_STATS_EN defined, CNT_W=2: five reads, three writes, one collision → rd_count=3 (saturated), wr_count=3, collision not counted.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port DEPTH x DATA_W memory responder with post-reset clear sequencer and sticky protocol-error flags.
// Optional access counters are enabled by defining MEM_RESPONDER_STATS_EN.
module mem_responder #(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 8,
  parameter int CLEAR_ON_RESET = 1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              err_collision,
  output logic              err_busy
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
`endif
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {CLEAR, IDLE} state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                err_col_q, err_col_d;
  logic                err_busy_q, err_busy_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    ready_d    = ready_q;
    data_out_d = data_out_q;
    err_col_d  = err_col_q;
    err_busy_d = err_busy_q;
    mem_we     = 1'b0;
    mem_waddr  = addr;
    mem_wdata  = data_in;

    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == ADDR_W'(DEPTH-1)) begin
          state_d   = IDLE;
          ready_d   = 1'b1;
          clr_ptr_d = '0;
        end
      end
      IDLE: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d = RST_STATE;
      end
    endcase

    // ready_q is only ever high in IDLE, so a clear write can never coincide with a bus write
    if (read || write) begin
      if (!ready_q) begin
        err_busy_d = 1'b1;
      end else if (read && write) begin
        err_col_d = 1'b1;
      end else if (write) begin
        mem_we = 1'b1;
      end else begin
        data_out_d = mem_q[addr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      clr_ptr_q  <= '0;
      ready_q    <= 1'b0;
      data_out_q <= '0;
      err_col_q  <= 1'b0;
      err_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      ready_q    <= ready_d;
      data_out_q <= data_out_d;
      err_col_q  <= err_col_d;
      err_busy_q <= err_busy_d;
    end
  end

  // Storage is deliberately not reset; the clear sequencer provides known contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign data_out      = data_out_q;
  assign ready         = ready_q;
  assign err_collision = err_col_q;
  assign err_busy      = err_busy_q;

`ifdef MEM_RESPONDER_STATS_EN
  logic              rd_acc, wr_acc;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

  assign rd_acc = ready_q & read & ~write;
  assign wr_acc = ready_q & write & ~read;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_acc && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + 1'b1;
    if (wr_acc && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder; counter checks run when MEM_RESPONDER_STATS_EN is defined.
module tb_mem_responder;

`ifdef MEM_RESPONDER_STATS_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  logic       clk;
  logic       rst_n;
  logic       read;
  logic       write;
  logic [4:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       ready;
  logic       err_collision;
  logic       err_busy;
`ifdef MEM_RESPONDER_STATS_EN
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] wr_count;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  mem_responder #(
    .ADDR_W(5), .DATA_W(8), .CLEAR_ON_RESET(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
    .data_in(data_in), .data_out(data_out), .ready(ready),
    .err_collision(err_collision), .err_busy(err_busy)
`ifdef MEM_RESPONDER_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a falling edge; returns there after the strobe edge has happened.
  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    write = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a);
    read = 1'b1; addr = a;
    @(negedge clk);
    read = 1'b0;
  endtask

  // Counts falling-edge samples with ready low, starting at the release point.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!ready && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic reset_release();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int cyc;

  initial begin
    rst_n = 1'b0; read = 1'b0; write = 1'b0; addr = '0; data_in = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_dout", data_out, 0);
    check("rst_err_col", err_collision, 0);
    check("rst_err_busy", err_busy, 0);

    rst_n = 1'b1;
    wait_ready(cyc);
    check("clear_window", cyc, 32);
    check("ready_after_clear", ready, 1);
    for (int a = 0; a < 32; a++) begin
      do_read(5'(a));
      check($sformatf("clr_rd_%0d", a), data_out, 8'h00);
    end

    // Busy strobe during clear, then reset mid-clear.
    reset_release();
    repeat (9) @(negedge clk);
    do_write(5'h07, 8'h77);
    check("busy_set", err_busy, 1);
    check("busy_ready_low", ready, 0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("busy_cleared_by_rst", err_busy, 0);
    check("ready_low_in_rst", ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(cyc);
    check("clear_restart_window", cyc, 32);
    do_read(5'h07);
    check("busy_write_ignored", data_out, 8'h00);

    do_write(5'h0A, 8'hA5);
    check("wr_no_dout_change", data_out, 8'h00);
    do_read(5'h0A);
    check("raw_a5", data_out, 8'hA5);
    repeat (3) @(negedge clk);
    check("dout_hold", data_out, 8'hA5);

    for (int a = 0; a < 32; a++) do_write(5'(a), 8'(a));
    for (int a = 0; a < 32; a++) begin
      do_read(5'(a));
      check($sformatf("sweep_rd_%0d", a), data_out, 32'(a));
    end
    check("sweep_err_col", err_collision, 0);
    check("sweep_err_busy", err_busy, 0);

    reset_release();
    wait_ready(cyc);
    check("clear_window_3", cyc, 32);
    do_write(5'h0A, 8'h5C);
    do_read(5'h0A);
    check("pre_col_rd", data_out, 8'h5C);
    read = 1'b1; write = 1'b1; addr = 5'h03; data_in = 8'hFF;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    check("col_flag", err_collision, 1);
    check("col_dout_held", data_out, 8'h5C);
    check("col_no_busy", err_busy, 0);
    do_read(5'h03);
    check("col_no_write", data_out, 8'h00);
    repeat (2) @(negedge clk);
    check("col_sticky", err_collision, 1);

`ifdef MEM_RESPONDER_STATS_EN
    reset_release();
    wait_ready(cyc);
    check("stats_rst_rd", rd_count, 0);
    check("stats_rst_wr", wr_count, 0);
    do_write(5'h01, 8'h11);
    do_write(5'h02, 8'h22);
    do_read(5'h01);
    check("stats_rd_1", rd_count, 1);
    do_write(5'h03, 8'h33);
    for (int i = 0; i < 4; i++) do_read(5'(i));
    read = 1'b1; write = 1'b1; addr = 5'h04;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    check("stats_rd_sat", rd_count, 3);
    check("stats_wr", wr_count, 3);
    check("stats_col_flag", err_collision, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
